instr_buffer: RTL and testbench

INSTR_BUFFER -- requirements
Module: instr_buffer

---
 rtl/instr_buffer.sv | 99 +++++++++
 tb/tb_instr_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and decode: compacts up to FETCH_WIDTH
// valid fetch slots per cycle and presents the oldest DECODE_WIDTH entries in order.
module instr_buffer #(
  parameter int DEPTH        = 8,
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          stall_i,
  input  logic [FETCH_WIDTH-1:0]        fetch_valid_i,
  input  logic [FETCH_WIDTH*32-1:0]     fetch_pc_i,
  input  logic [FETCH_WIDTH*32-1:0]     fetch_instr_i,
  output logic                          frontend_stallreq_o,
  output logic [DECODE_WIDTH-1:0]       dispatch_valid_o,
  output logic [DECODE_WIDTH*32-1:0]    dispatch_pc_o,
  output logic [DECODE_WIDTH*32-1:0]    dispatch_instr_o,
  input  logic [DECODE_WIDTH-1:0]       dispatch_accept_i,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          push_en;
  logic          pop_run;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;
  logic [PW-1:0] slot_off [FETCH_WIDTH];

  // Stall whenever a full fetch group might not fit, regardless of how many slots are valid.
  assign frontend_stallreq_o = (CW'(DEPTH) - count) < CW'(FETCH_WIDTH);
  assign push_en             = !frontend_stallreq_o && !flush_i;
  assign count_o             = count;

  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_off[i] = push_cnt[PW-1:0];
      if (push_en && fetch_valid_i[i]) begin
        push_cnt = push_cnt + CW'(1);
      end
    end
  end

  // Pops retire a contiguous prefix of the head window so dispatch stays in order.
  always_comb begin
    pop_cnt = '0;
    pop_run = !(stall_i || flush_i);
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      pop_run = pop_run && dispatch_accept_i[i] && dispatch_valid_o[i];
      if (pop_run) begin
        pop_cnt = pop_cnt + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_disp
    logic [PW-1:0] rd_idx;
    assign rd_idx                       = head + PW'(g);
    assign dispatch_valid_o[g]          = count > CW'(g);
    assign dispatch_pc_o[g*32 +: 32]    = dispatch_valid_o[g] ? pc_mem[rd_idx]    : 32'h0;
    assign dispatch_instr_o[g*32 +: 32] = dispatch_valid_o[g] ? instr_mem[rd_idx] : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_cnt[PW-1:0];
      tail  <= tail + push_cnt[PW-1:0];
      count <= count + push_cnt - pop_cnt;
    end
  end

  // Storage is never reset; stale entries are hidden by the count-based valid gating.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (push_en && fetch_valid_i[i]) begin
        pc_mem[tail + slot_off[i]]    <= fetch_pc_i[i*32 +: 32];
        instr_mem[tail + slot_off[i]] <= fetch_instr_i[i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: fetched entries are queued when driven and
// compared against the dispatch ports as they are accepted.
module tb_instr_buffer;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam logic [31:0] IXOR = 32'h5a5a_0f0f;

  logic            clk;
  logic            rst;
  logic            flush_i;
  logic            stall_i;
  logic [FW-1:0]   fetch_valid_i;
  logic [FW*32-1:0] fetch_pc_i;
  logic [FW*32-1:0] fetch_instr_i;
  logic            frontend_stallreq_o;
  logic [DW-1:0]   dispatch_valid_o;
  logic [DW*32-1:0] dispatch_pc_o;
  logic [DW*32-1:0] dispatch_instr_o;
  logic [DW-1:0]   dispatch_accept_i;
  logic [$clog2(DEPTH):0] count_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] next_pc;

  instr_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .stall_i             (stall_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_instr_i       (fetch_instr_i),
    .frontend_stallreq_o (frontend_stallreq_o),
    .dispatch_valid_o    (dispatch_valid_o),
    .dispatch_pc_o       (dispatch_pc_o),
    .dispatch_instr_o    (dispatch_instr_o),
    .dispatch_accept_i   (dispatch_accept_i),
    .count_o             (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares the whole visible state against the scoreboard without consuming it.
  task automatic checkState(input string tag);
    logic [DW-1:0] ev;
    checkOutput({tag, "_count"}, 64'(count_o), 64'(exp_q.size()));
    for (int i = 0; i < DW; i++) ev[i] = exp_q.size() > i;
    checkOutput({tag, "_valid"}, 64'(dispatch_valid_o), 64'(ev));
    for (int i = 0; i < DW; i++)
      checkOutput($sformatf("%s_slot%0d", tag, i),
                  {dispatch_instr_o[i*32 +: 32], dispatch_pc_o[i*32 +: 32]},
                  (exp_q.size() > i) ? exp_q[i] : 64'h0);
    checkOutput({tag, "_stallreq"}, 64'(frontend_stallreq_o),
                64'((DEPTH - exp_q.size()) < FW));
  endtask

  // Drives one cycle of inputs, updates the scoreboard, then checks after the edge.
  task automatic applyStimulus(input logic [1:0] fv, input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [1:0] acc, input logic st, input logic fl,
                               input string tag);
    bit m_stall;
    int npop;
    logic [63:0] e;
    logic [31:0] pcs [2];
    pcs[0] = pc0;
    pcs[1] = pc1;
    fetch_valid_i     = fv;
    fetch_pc_i        = {pc1, pc0};
    fetch_instr_i     = {pc1 ^ IXOR, pc0 ^ IXOR};
    dispatch_accept_i = acc;
    stall_i           = st;
    flush_i           = fl;
    #1;
    m_stall = (DEPTH - exp_q.size()) < FW;
    if (fl) begin
      exp_q.delete();
    end else begin
      npop = 0;
      if (!st && acc[0] && exp_q.size() > 0) begin
        npop = 1;
        if (acc[1] && exp_q.size() > 1) npop = 2;
      end
      for (int k = 0; k < npop; k++) begin
        e = exp_q.pop_front();
        checkOutput({tag, "_pop"}, {dispatch_instr_o[k*32 +: 32], dispatch_pc_o[k*32 +: 32]}, e);
      end
      if (!m_stall)
        for (int s = 0; s < FW; s++)
          if (fv[s]) exp_q.push_back({pcs[s] ^ IXOR, pcs[s]});
    end
    @(posedge clk);
    #1;
    fetch_valid_i     = '0;
    dispatch_accept_i = '0;
    stall_i           = 1'b0;
    flush_i           = 1'b0;
    checkState(tag);
  endtask

  task automatic pushPair(input string tag);
    applyStimulus(2'b11, next_pc, next_pc + 32'd4, 2'b00, 1'b0, 1'b0, tag);
    next_pc = next_pc + 32'd8;
  endtask

  initial begin
    logic [1:0] rv;
    logic [1:0] ra;
    logic       rs;
    rst               = 1'b1;
    flush_i           = 1'b0;
    stall_i           = 1'b0;
    fetch_valid_i     = '0;
    fetch_pc_i        = '0;
    fetch_instr_i     = '0;
    dispatch_accept_i = '0;
    next_pc           = 32'h0000_1000;
    repeat (2) @(posedge clk);
    #1;
    checkState("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic push and visibility one cycle later
    applyStimulus(2'b11, 32'h1c00_0000, 32'h1c00_0004, 2'b00, 1'b0, 1'b0, "push2");
    checkOutput("push2_pc1", 64'(dispatch_pc_o[63:32]), 64'h1c00_0004);

    // Single pop, then out-of-order accept must not pop
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, "pop1");
    checkOutput("pop1_pc0", 64'(dispatch_pc_o[31:0]), 64'h1c00_0004);
    pushPair("refill");
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, "acc10");

    // Only the upper fetch slot valid into an empty buffer
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, "flush_a");
    applyStimulus(2'b10, 32'hdead_0000, 32'h2000_0010, 2'b00, 1'b0, 1'b0, "slot1only");
    checkOutput("slot1only_pc", 64'(dispatch_pc_o[31:0]), 64'h2000_0010);

    // Fill to 7, push ignored while stalled, then pop two with a blocked push
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, "flush_b");
    repeat (3) pushPair("fill");
    applyStimulus(2'b01, next_pc, 32'h0, 2'b00, 1'b0, 1'b0, "fill7");
    next_pc = next_pc + 32'd4;
    checkOutput("full_stallreq", 64'(frontend_stallreq_o), 64'h1);
    applyStimulus(2'b11, 32'h7777_0000, 32'h7777_0004, 2'b00, 1'b0, 1'b0, "push_ignored");
    applyStimulus(2'b11, 32'h7777_0008, 32'h7777_000c, 2'b11, 1'b0, 1'b0, "drain2");
    checkOutput("drain2_count", 64'(count_o), 64'd5);
    checkOutput("drain2_stallreq", 64'(frontend_stallreq_o), 64'h0);

    // Flush beats simultaneous push and pop
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, "flush_c");
    repeat (2) pushPair("four");
    applyStimulus(2'b11, 32'h8888_0000, 32'h8888_0004, 2'b11, 1'b0, 1'b1, "flush_busy");
    checkOutput("flush_busy_count", 64'(count_o), 64'd0);

    // Stall freezes the head window while pushes continue
    pushPair("pre_stall");
    applyStimulus(2'b11, next_pc, next_pc + 32'd4, 2'b11, 1'b1, 1'b0, "stall1");
    next_pc = next_pc + 32'd8;
    applyStimulus(2'b01, next_pc, 32'h0, 2'b11, 1'b1, 1'b0, "stall2");
    next_pc = next_pc + 32'd4;

    // Streaming push-2/pop-2 wraps the pointers several times
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, "flush_d");
    pushPair("prime");
    for (int c = 0; c < 20; c++) begin
      applyStimulus(2'b11, next_pc, next_pc + 32'd4, 2'b11, 1'b0, 1'b0, "stream");
      next_pc = next_pc + 32'd8;
    end

    // Mixed random traffic
    for (int c = 0; c < 40; c++) begin
      rv = 2'($urandom_range(0, 3));
      ra = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 5) == 0);
      applyStimulus(rv, next_pc, next_pc + 32'd4, ra, rs, 1'b0, "rand");
      next_pc = next_pc + 32'd8;
    end

    // Asynchronous reset between clock edges
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, "flush_e");
    pushPair("pre_rst");
    pushPair("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkState("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pushPair("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
